// File: rtl/regfile_pkg.sv
// Shared widths and write-back FSM encoding for the register file write-back path.
package regfile_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned HI_REG = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard for pending mul/div destinations, with decode queries and a sticky WAW flag.
module wb_scoreboard #(
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
  parameter int unsigned HI_REG = regfile_pkg::HI_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_reg,
  input  logic              clr_lo,
  input  logic [ADDR_W-1:0] clr_lo_reg,
  input  logic              clr_hi,
  input  logic [ADDR_W-1:0] q_reg1,
  input  logic [ADDR_W-1:0] q_reg2,
  output logic              hazard1,
  output logic              hazard2,
  input  logic              chk_en,
  input  logic [ADDR_W-1:0] chk_reg,
  output logic              err_waw
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Issue marks Rd and HI; set masks are applied after clears so a set always wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) begin
      set_mask[set_reg]           = 1'b1;
      set_mask[ADDR_W'(HI_REG)]   = 1'b1;
    end
    if (clr_lo) clr_mask[clr_lo_reg]        = 1'b1;
    if (clr_hi) clr_mask[ADDR_W'(HI_REG)]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_waw <= 1'b0;
    end else if (chk_en && busy[chk_reg]) begin
      err_waw <= 1'b1;
    end
  end

  assign hazard1 = busy[q_reg1];
  assign hazard2 = busy[q_reg2];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: arbitrates the single register file write port between ALU and mul/div results.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W    = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W    = regfile_pkg::ADDR_W,
  parameter int unsigned HI_REG    = regfile_pkg::HI_REG,
  parameter int unsigned MAX_DEFER = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_reg,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_stall,
  input  logic                md_issue,
  input  logic [ADDR_W-1:0]   md_issue_reg,
  input  logic                md_valid,
  output logic                md_ready,
  input  logic [ADDR_W-1:0]   md_reg,
  input  logic [2*DATA_W-1:0] md_data,
  input  logic [ADDR_W-1:0]   q_reg1,
  input  logic [ADDR_W-1:0]   q_reg2,
  output logic                hazard1,
  output logic                hazard2,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                err_waw
);

  localparam int unsigned CNT_W = (MAX_DEFER < 1) ? 1 : $clog2(MAX_DEFER + 1);

  wb_state_t           state;
  wb_state_t           state_n;
  logic [CNT_W-1:0]    defer_cnt;
  logic [CNT_W-1:0]    defer_cnt_n;
  logic [ADDR_W-1:0]   hold_reg;
  logic [2*DATA_W-1:0] hold_data;

  logic                pending;
  logic                defer_max;
  logic                md_commit;
  logic                alu_commit;
  logic                accept;
  logic                we_n;
  logic [ADDR_W-1:0]   waddr_n;
  logic [DATA_W-1:0]   wdata_n;

  assign pending    = (state != IDLE);
  assign defer_max  = (defer_cnt == CNT_W'(MAX_DEFER));
  assign md_commit  = pending && (!alu_valid || defer_max);
  assign alu_commit = alu_valid && !md_commit;
  assign md_ready   = (state == IDLE);
  assign accept     = md_valid && md_ready;
  assign alu_stall  = alu_valid && md_commit && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      defer_cnt <= '0;
    end else begin
      state     <= state_n;
      defer_cnt <= defer_cnt_n;
    end
  end

  // Next state, defer count and the winning write for this cycle.
  always_comb begin
    state_n     = state;
    defer_cnt_n = defer_cnt;
    we_n        = 1'b0;
    waddr_n     = rf_waddr;
    wdata_n     = rf_wdata;

    case (state)
      IDLE:    if (accept)    state_n = WR_LO;
      WR_LO:   if (md_commit) state_n = WR_HI;
      WR_HI:   if (md_commit) state_n = IDLE;
      default:                state_n = IDLE;
    endcase

    if (md_commit) begin
      we_n        = 1'b1;
      defer_cnt_n = '0;
      if (state == WR_LO) begin
        waddr_n = hold_reg;
        wdata_n = hold_data[DATA_W-1:0];
      end else begin
        waddr_n = ADDR_W'(HI_REG);
        wdata_n = hold_data[2*DATA_W-1:DATA_W];
      end
    end else if (alu_commit) begin
      we_n    = 1'b1;
      waddr_n = alu_reg;
      wdata_n = alu_data;
      if (pending) defer_cnt_n = defer_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg  <= '0;
      hold_data <= '0;
    end else if (accept) begin
      hold_reg  <= md_reg;
      hold_data <= md_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we    <= we_n;
      rf_waddr <= waddr_n;
      rf_wdata <= wdata_n;
    end
  end

  wb_scoreboard #(
    .ADDR_W (ADDR_W),
    .HI_REG (HI_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (md_issue),
    .set_reg    (md_issue_reg),
    .clr_lo     (md_commit && (state == WR_LO)),
    .clr_lo_reg (hold_reg),
    .clr_hi     (md_commit && (state == WR_HI)),
    .q_reg1     (q_reg1),
    .q_reg2     (q_reg2),
    .hazard1    (hazard1),
    .hazard2    (hazard2),
    .chk_en     (alu_commit),
    .chk_reg    (alu_reg),
    .err_waw    (err_waw)
  );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with hand-computed expectations.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [3:0]  alu_reg;
  logic [15:0] alu_data;
  logic        alu_stall;
  logic        md_issue;
  logic [3:0]  md_issue_reg;
  logic        md_valid;
  logic        md_ready;
  logic [3:0]  md_reg;
  logic [31:0] md_data;
  logic [3:0]  q_reg1;
  logic [3:0]  q_reg2;
  logic        hazard1;
  logic        hazard2;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        err_waw;

  int total = 0;
  int bad   = 0;

  regfile_wb_scheduler #(
    .DATA_W(16), .ADDR_W(4), .HI_REG(15), .MAX_DEFER(2)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_stall(alu_stall),
    .md_issue(md_issue), .md_issue_reg(md_issue_reg),
    .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
    .q_reg1(q_reg1), .q_reg2(q_reg2), .hazard1(hazard1), .hazard2(hazard2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .err_waw(err_waw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [3:0] addr, input logic [15:0] data);
    check({tag, ".we"},    32'(rf_we), 32'd1);
    check({tag, ".addr"},  32'(rf_waddr), 32'(addr));
    check({tag, ".data"},  32'(rf_wdata), 32'(data));
  endtask

  task automatic issue(input logic [3:0] r);
    md_issue = 1'b1; md_issue_reg = r;
    tick();
    md_issue = 1'b0;
  endtask

  task automatic offer(input logic [3:0] r, input logic [31:0] d);
    md_valid = 1'b1; md_reg = r; md_data = d;
    tick();
    md_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    md_issue = 1'b0; md_issue_reg = '0; md_valid = 1'b0; md_reg = '0; md_data = '0;
    q_reg1 = '0; q_reg2 = '0;

    // reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst.we",    32'(rf_we), 32'd0);
    check("rst.addr",  32'(rf_waddr), 32'd0);
    check("rst.data",  32'(rf_wdata), 32'd0);
    check("rst.waw",   32'(err_waw), 32'd0);
    check("rst.ready", 32'(md_ready), 32'd1);
    check("rst.stall", 32'(alu_stall), 32'd0);
    check("rst.haz",   32'(hazard1), 32'd0);

    // ALU only
    alu_valid = 1'b1; alu_reg = 4'd3; alu_data = 16'h1234;
    tick();
    alu_valid = 1'b0;
    check_wr("alu", 4'd3, 16'h1234);
    check("alu.ready", 32'(md_ready), 32'd1);
    tick();
    check("alu.idle_we", 32'(rf_we), 32'd0);

    // mul/div with idle ALU
    q_reg1 = 4'd5; q_reg2 = 4'd15;
    issue(4'd5);
    check("md.haz5", 32'(hazard1), 32'd1);
    check("md.haz15", 32'(hazard2), 32'd1);
    offer(4'd5, 32'hABCD_0042);
    check("md.ready_lo", 32'(md_ready), 32'd0);
    check("md.we_acc", 32'(rf_we), 32'd0);
    tick();
    check_wr("md.lo", 4'd5, 16'h0042);
    check("md.haz5_clr", 32'(hazard1), 32'd0);
    check("md.haz15_hold", 32'(hazard2), 32'd1);
    tick();
    check_wr("md.hi", 4'd15, 16'hABCD);
    check("md.haz15_clr", 32'(hazard2), 32'd0);
    check("md.ready_idle", 32'(md_ready), 32'd1);
    tick();
    check("md.idle_we", 32'(rf_we), 32'd0);

    // ALU contention with MAX_DEFER=2
    q_reg1 = 4'd7;
    issue(4'd7);
    offer(4'd7, 32'h5555_1111);
    alu_valid = 1'b1; alu_reg = 4'd2; alu_data = 16'h0202;
    #1;
    check("ct.stall0", 32'(alu_stall), 32'd0);
    tick();
    check_wr("ct.alu1", 4'd2, 16'h0202);
    alu_reg = 4'd3; alu_data = 16'h0303;
    #1;
    check("ct.stall1", 32'(alu_stall), 32'd0);
    tick();
    check_wr("ct.alu2", 4'd3, 16'h0303);
    check("ct.stall2", 32'(alu_stall), 32'd1);
    tick();
    check_wr("ct.lo", 4'd7, 16'h1111);
    check("ct.stall_clr", 32'(alu_stall), 32'd0);
    check("ct.haz7", 32'(hazard1), 32'd0);
    tick();
    check_wr("ct.alu3", 4'd3, 16'h0303);
    alu_valid = 1'b0;
    tick();
    check_wr("ct.hi", 4'd15, 16'h5555);
    check("ct.ready", 32'(md_ready), 32'd1);
    check("ct.waw", 32'(err_waw), 32'd0);

    // same-cycle issue and lo-commit clear
    q_reg1 = 4'd5; q_reg2 = 4'd15;
    issue(4'd5);
    offer(4'd5, 32'h0000_0099);
    issue(4'd5);
    check_wr("sc.lo", 4'd5, 16'h0099);
    check("sc.haz5_set", 32'(hazard1), 32'd1);
    tick();
    check_wr("sc.hi", 4'd15, 16'h0000);
    check("sc.haz5_keep", 32'(hazard1), 32'd1);
    offer(4'd5, 32'h0001_0002);
    tick();
    check("sc.haz5_clr", 32'(hazard1), 32'd0);
    tick();

    // WAW on busy HI register
    issue(4'd9);
    alu_valid = 1'b1; alu_reg = 4'd15; alu_data = 16'h0F0F;
    tick();
    alu_valid = 1'b0;
    check_wr("waw.wr", 4'd15, 16'h0F0F);
    check("waw.flag", 32'(err_waw), 32'd1);
    tick(); tick();
    check("waw.sticky", 32'(err_waw), 32'd1);
    offer(4'd9, 32'h2222_3333);
    tick(); tick();

    // Rd == HI_REG: lo then hi both land on R15
    issue(4'd15);
    offer(4'd15, 32'hBEEF_CAFE);
    tick();
    check_wr("hh.lo", 4'd15, 16'hCAFE);
    tick();
    check_wr("hh.hi", 4'd15, 16'hBEEF);
    check("hh.haz15", 32'(hazard2), 32'd0);
    tick();

    // reset while hi half is pending
    q_reg1 = 4'd4; q_reg2 = 4'd15;
    issue(4'd4);
    offer(4'd4, 32'h7777_4444);
    tick();
    check_wr("rs.lo", 4'd4, 16'h4444);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rs.we",    32'(rf_we), 32'd0);
    check("rs.addr",  32'(rf_waddr), 32'd0);
    check("rs.data",  32'(rf_wdata), 32'd0);
    check("rs.waw",   32'(err_waw), 32'd0);
    check("rs.ready", 32'(md_ready), 32'd1);
    check("rs.stall", 32'(alu_stall), 32'd0);
    check("rs.haz4",  32'(hazard1), 32'd0);
    check("rs.haz15", 32'(hazard2), 32'd0);
    tick();
    check("rs.we_after",    32'(rf_we), 32'd0);
    check("rs.ready_after", 32'(md_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
